// File: rtl/mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// mem_arb_pkg
//
// Shared definitions for the data-memory port arbiter.
//
//   owner_e   - who owns the read word coming back from the RAM in the
//               current cycle (the read granted one cycle earlier).
//               CPU writes and idle cycles record NONE because nothing
//               comes back for them.
//   STREAK_W  - width of the consecutive-video-grant counter. It is four
//               bits, so the video burst limit can be at most 15.
// ----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int STREAK_W = 4;

    typedef enum logic [1:0] {
        NONE   = 2'b00,
        CPU_RD = 2'b01,
        VID_RD = 2'b10
    } owner_e;

endpackage : mem_arb_pkg

// File: rtl/arb_streak_counter.sv
// ----------------------------------------------------------------------------
// arb_streak_counter
//
// Counts consecutive video grants that were made while the CPU was left
// waiting. Once the count reaches LIMIT, limit_hit_o tells the arbiter to
// hand the next slot to the CPU. The count saturates at LIMIT instead of
// wrapping, so the CPU keeps its claim until it is actually granted.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-low
//   clr_i        clear the count (CPU granted, or CPU not requesting)
//   inc_i        video was granted while the CPU was requesting
//   limit_hit_o  count has reached LIMIT
//
// LIMIT must lie in 1 .. 2**WIDTH-1.
// ----------------------------------------------------------------------------
module arb_streak_counter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH = STREAK_W,
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic inc_i,
    output logic limit_hit_o
);

    localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign limit_hit_o = (count_q == LIMIT_V);

    // Clear has priority. Holding at LIMIT stops the count from wrapping
    // back to zero while the CPU is still waiting.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && !limit_hit_o) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule : arb_streak_counter

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single synchronous-read data-memory port between the CPU and
// the display scanout engine. Video has priority so pixel deadlines are met.
// After VID_BURST_MAX consecutive video grants taken while the CPU was
// waiting, the CPU gets the next slot. Each word read back from the RAM is
// tagged with its owner through cpu_rvalid / vid_rvalid.
//
// Ports:
//   clk, reset                   clock; asynchronous active-low reset
//   cpu_req/we/addr/wdata        CPU request, held until cpu_gnt
//   cpu_gnt                      CPU access accepted this cycle
//   cpu_rvalid, cpu_rdata        CPU read return, one cycle after grant
//   vid_req/addr                 video read request, held until vid_gnt
//   vid_gnt                      video access accepted this cycle
//   vid_rvalid, vid_rdata        video read return, one cycle after grant
//   mem_addr/wdata/we            steered RAM command
//   mem_rdata                    RAM read data, registered, 1-cycle latency
//
// VID_BURST_MAX must lie in 1..15.
// ----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 16,
    parameter int VID_BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_gnt,
    output logic              vid_rvalid,
    output logic [DATA_W-1:0] vid_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    owner_e owner_q;
    owner_e owner_d;

    logic cpu_req_act;
    logic vid_req_act;
    logic limit_hit;

    // Grants are combinational, so the requests are masked with reset.
    // This keeps grants and mem_we at zero while reset is held, even
    // though the requesters may still be asserting req.
    assign cpu_req_act = cpu_req & reset;
    assign vid_req_act = vid_req & reset;

    // The streak only grows while the CPU is actually waiting. It is
    // cleared when the CPU is served or when the CPU stops requesting.
    arb_streak_counter #(
        .WIDTH (STREAK_W),
        .LIMIT (VID_BURST_MAX)
    ) u_streak (
        .clk         (clk),
        .reset       (reset),
        .clr_i       (cpu_gnt | ~cpu_req_act),
        .inc_i       (vid_gnt & cpu_req_act),
        .limit_hit_o (limit_hit)
    );

    // Grant selection and RAM command steering. Video wins unless the
    // CPU is waiting and the video streak has reached its limit. The
    // owner recorded for next cycle follows the granted read. A CPU write
    // returns nothing, so it records NONE, the same as an idle cycle.
    always_comb begin
        cpu_gnt   = 1'b0;
        vid_gnt   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        owner_d   = NONE;

        if (vid_req_act && !(cpu_req_act && limit_hit)) begin
            vid_gnt  = 1'b1;
            mem_addr = vid_addr;
            owner_d  = VID_RD;
        end else if (cpu_req_act) begin
            cpu_gnt   = 1'b1;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_we    = cpu_we;
            owner_d   = cpu_we ? NONE : CPU_RD;
        end
    end

    // Owner of the word the RAM presents next cycle. Reset clears it
    // asynchronously, which drops any read that is still in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q <= NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    // Both consumers see the raw RAM word. Only the owner gets a valid
    // strobe. Gating the strobes with reset keeps them low for the whole
    // reset window, not just after the register has cleared.
    assign cpu_rvalid = reset && (owner_q == CPU_RD);
    assign vid_rvalid = reset && (owner_q == VID_RD);
    assign cpu_rdata  = mem_rdata;
    assign vid_rdata  = mem_rdata;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Bench for mem_port_arbiter with a behavioural synchronous RAM attached.
// Grants are checked from a vector table and from hand-written sequences.
// Read returns are checked by a scoreboard that queues the expected owner
// and data when a read is granted.
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int BURST = 4;

    logic          clk;
    logic          resetN;
    logic          cpuReq;
    logic          cpuWe;
    logic [AW-1:0] cpuAddr;
    logic [DW-1:0] cpuWdata;
    logic          cpuGnt;
    logic          cpuRvalid;
    logic [DW-1:0] cpuRdata;
    logic          vidReq;
    logic [AW-1:0] vidAddr;
    logic          vidGnt;
    logic          vidRvalid;
    logic [DW-1:0] vidRdata;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memWdata;
    logic          memWe;
    logic [DW-1:0] memRdata;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic          isCpu;
        logic [DW-1:0] data;
    } expRead_t;

    expRead_t sbQ[$];

    typedef struct {
        logic cReq;
        logic cWe;
        logic vReq;
        logic expCpuGnt;
        logic expVidGnt;
        logic expMemWe;
    } vec_t;

    vec_t vec[10];

    logic [DW-1:0] ram    [0:(1<<AW)-1];
    logic [DW-1:0] refMem [0:(1<<AW)-1];

    mem_port_arbiter #(
        .ADDR_W        (AW),
        .DATA_W        (DW),
        .VID_BURST_MAX (BURST)
    ) dut (
        .clk        (clk),
        .reset      (resetN),
        .cpu_req    (cpuReq),
        .cpu_we     (cpuWe),
        .cpu_addr   (cpuAddr),
        .cpu_wdata  (cpuWdata),
        .cpu_gnt    (cpuGnt),
        .cpu_rvalid (cpuRvalid),
        .cpu_rdata  (cpuRdata),
        .vid_req    (vidReq),
        .vid_addr   (vidAddr),
        .vid_gnt    (vidGnt),
        .vid_rvalid (vidRvalid),
        .vid_rdata  (vidRdata),
        .mem_addr   (memAddr),
        .mem_wdata  (memWdata),
        .mem_we     (memWe),
        .mem_rdata  (memRdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural block RAM: registered read with one cycle of latency.
    // A write commits on the edge that ends the grant cycle.
    always @(posedge clk) begin
        if (memWe) ram[memAddr] <= memWdata;
        memRdata <= ram[memAddr];
    end

    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    // Drive a new set of requests 1 ns after the rising edge.
    task automatic applyStimulus(input logic cReq, input logic cWe,
                                 input logic [AW-1:0] cAddr, input logic [DW-1:0] cWd,
                                 input logic vReq, input logic [AW-1:0] vAddr);
        @(posedge clk);
        #1;
        cpuReq   = cReq;
        cpuWe    = cWe;
        cpuAddr  = cAddr;
        cpuWdata = cWd;
        vidReq   = vReq;
        vidAddr  = vAddr;
    endtask

    // Both requesters keep asking for n cycles. Each side moves to a new
    // address only after it has been granted. The expected grant pattern
    // comes from the bench's own count of video grants made while the CPU
    // waited.
    task automatic runContention(input int n, input string tag);
        int streak = 0;
        int cIdx   = 0;
        int vIdx   = 0;
        logic expV;
        for (int c = 0; c < n; c++) begin
            applyStimulus(1'b1, 1'b0, AW'(16'h0030 + cIdx), '0, 1'b1, AW'(16'h0100 + vIdx));
            expV = (streak != BURST);
            @(negedge clk);
            checkOutput($sformatf("%s_c%0d_vid_gnt", tag, c), DW'(vidGnt), DW'(expV));
            checkOutput($sformatf("%s_c%0d_cpu_gnt", tag, c), DW'(cpuGnt), DW'(!expV));
            if (expV) begin
                streak++;
                vIdx++;
            end else begin
                streak = 0;
                cIdx   = (cIdx + 1) % 3;
            end
        end
    endtask

    // Scoreboard. A read granted in one cycle must return on the next
    // cycle to the right owner with the right data. An empty queue means
    // no strobe may be set. Reset discards anything that is outstanding.
    always @(negedge clk) begin
        expRead_t e;
        if (!resetN) begin
            sbQ.delete();
            checkOutput("rst_cpu_rvalid", DW'(cpuRvalid), '0);
            checkOutput("rst_vid_rvalid", DW'(vidRvalid), '0);
        end else begin
            if (sbQ.size() > 0) begin
                e = sbQ.pop_front();
                checkOutput("sb_cpu_rvalid", DW'(cpuRvalid), DW'(e.isCpu));
                checkOutput("sb_vid_rvalid", DW'(vidRvalid), DW'(!e.isCpu));
                checkOutput("sb_rdata", e.isCpu ? cpuRdata : vidRdata, e.data);
            end else begin
                checkOutput("idle_cpu_rvalid", DW'(cpuRvalid), '0);
                checkOutput("idle_vid_rvalid", DW'(vidRvalid), '0);
            end
            if (vidGnt) begin
                sbQ.push_back('{1'b0, refMem[vidAddr]});
            end else if (cpuGnt && !cpuWe) begin
                sbQ.push_back('{1'b1, refMem[cpuAddr]});
            end
            if (cpuGnt && cpuWe) refMem[cpuAddr] = cpuWdata;
        end
    end

    initial begin
        // Preload both the RAM and the bench's reference copy.
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i]    = DW'(i) ^ 16'hC3C3;
            refMem[i] = DW'(i) ^ 16'hC3C3;
        end
        ram[16'h0010]    = 16'hBEEF;
        refMem[16'h0010] = 16'hBEEF;

        // Fields: cReq, cWe, vReq -> expected cpu_gnt, vid_gnt, mem_we
        vec[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vec[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vec[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vec[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vec[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vec[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vec[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vec[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vec[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset with both requesters already asking.
        resetN   = 1'b1;
        cpuReq   = 1'b1;
        cpuWe    = 1'b0;
        cpuAddr  = 16'h0010;
        cpuWdata = '0;
        vidReq   = 1'b1;
        vidAddr  = 16'h0040;
        #2 resetN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("rst_cpu_gnt", DW'(cpuGnt), '0);
            checkOutput("rst_vid_gnt", DW'(vidGnt), '0);
            checkOutput("rst_mem_we", DW'(memWe), '0);
        end
        @(posedge clk);
        #1 resetN = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_vid_gnt", DW'(vidGnt), 16'd1);
        checkOutput("post_rst_cpu_gnt", DW'(cpuGnt), '0);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0);

        // Table-driven grant vectors.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vec[i].cReq, vec[i].cWe, 16'h0030, 16'h5A5A, vec[i].vReq, 16'h0040);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_cpu_gnt", i), DW'(cpuGnt), DW'(vec[i].expCpuGnt));
            checkOutput($sformatf("vec%0d_vid_gnt", i), DW'(vidGnt), DW'(vec[i].expVidGnt));
            checkOutput($sformatf("vec%0d_mem_we", i), DW'(memWe), DW'(vec[i].expMemWe));
            if (!vec[i].cReq && !vec[i].vReq) begin
                checkOutput($sformatf("vec%0d_mem_addr", i), memAddr, '0);
                checkOutput($sformatf("vec%0d_mem_wdata", i), memWdata, '0);
            end
        end

        // CPU alone reads 0x0010.
        applyStimulus(1'b1, 1'b0, 16'h0010, '0, 1'b0, '0);
        @(negedge clk);
        checkOutput("cpu_rd_gnt", DW'(cpuGnt), 16'd1);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0);
        @(negedge clk);
        checkOutput("cpu_rd_rvalid", DW'(cpuRvalid), 16'd1);
        checkOutput("cpu_rd_data", cpuRdata, 16'hBEEF);
        checkOutput("cpu_rd_vid_rvalid", DW'(vidRvalid), '0);

        // CPU write, then read-back of the same word.
        applyStimulus(1'b1, 1'b1, 16'h0020, 16'h1234, 1'b0, '0);
        @(negedge clk);
        checkOutput("wr_mem_we", DW'(memWe), 16'd1);
        checkOutput("wr_gnt", DW'(cpuGnt), 16'd1);
        applyStimulus(1'b1, 1'b0, 16'h0020, '0, 1'b0, '0);
        @(negedge clk);
        checkOutput("rdback_mem_we", DW'(memWe), '0);
        checkOutput("wr_no_rvalid", DW'(cpuRvalid), '0);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0);
        @(negedge clk);
        checkOutput("rdback_rvalid", DW'(cpuRvalid), 16'd1);
        checkOutput("rdback_data", cpuRdata, 16'h1234);

        // Continuous contention: V,V,V,V,C repeating.
        runContention(15, "burst");
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0);

        // Video alone for ten cycles, then contention again from streak 0.
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, AW'(16'h0200 + c));
            @(negedge clk);
            checkOutput($sformatf("vid_only%0d_vid_gnt", c), DW'(vidGnt), 16'd1);
            checkOutput($sformatf("vid_only%0d_cpu_gnt", c), DW'(cpuGnt), '0);
        end
        runContention(5, "after_vid");
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0);

        // Reset lands while a CPU read is in flight.
        applyStimulus(1'b1, 1'b0, 16'h0010, '0, 1'b0, '0);
        @(negedge clk);
        checkOutput("midrst_gnt", DW'(cpuGnt), 16'd1);
        @(posedge clk);
        #1 resetN = 1'b0;
        #1;
        checkOutput("midrst_cpu_rvalid", DW'(cpuRvalid), '0);
        checkOutput("midrst_cpu_gnt", DW'(cpuGnt), '0);
        repeat (2) @(posedge clk);
        #1 resetN = 1'b1;
        @(negedge clk);
        checkOutput("post_midrst_gnt", DW'(cpuGnt), 16'd1);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0);
        @(negedge clk);
        checkOutput("post_midrst_rvalid", DW'(cpuRvalid), 16'd1);
        checkOutput("post_midrst_data", cpuRdata, 16'hBEEF);

        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0);
        @(negedge clk);
        checkOutput("sb_drain", DW'(sbQ.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mem_port_arbiter
